// File: rtl/stage_mem.sv
// Memory stage: EX/MEM latch, data-memory handshake with stall until dhit,
// branch/jump redirect, MEM forwarding value and MEM/WB payload.
module stage_mem #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic [WORD_W-1:0] aluOut_in,
    input  logic [WORD_W-1:0] rdat2_in,
    input  logic [REG_W-1:0]  regSel_in,
    input  logic [WORD_W-1:0] npc_in,
    input  logic [WORD_W-1:0] branchaddr_in,
    input  logic [WORD_W-1:0] jumpaddr_in,
    input  logic [7:0]        ctrl_in,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              pc_redirect,
    output logic [WORD_W-1:0] pc_target,
    output logic [WORD_W-1:0] for_dat_mem,
    output logic [WORD_W-1:0] wdat_out,
    output logic [REG_W-1:0]  regSel_out,
    output logic              regWrite_out,
    output logic              halt_out
);

    typedef struct packed {
        logic reg_write, mem_read, mem_write, mem_to_reg, jal, halt, branch_sel, jump;
    } ctrl_t;

    typedef struct packed {
        logic [WORD_W-1:0] alu, rdat2, npc, baddr, jaddr;
        logic [REG_W-1:0]  reg_sel;
        ctrl_t             ctrl;
    } exmem_t;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_n;
    exmem_t            q, ex_in;
    ctrl_t             c_in;
    logic [WORD_W-1:0] ld_hold, load_data;
    logic              halt_q, adv, bubble, mem_op_in;

    assign c_in  = ctrl_t'(ctrl_in);
    assign ex_in = '{alu: aluOut_in, rdat2: rdat2_in, npc: npc_in, baddr: branchaddr_in,
                     jaddr: jumpaddr_in, reg_sel: regSel_in, ctrl: c_in};

    assign adv       = en & ~mem_stall;
    // once halted, nothing further is allowed to reach memory
    assign bubble    = flush | halt_out;
    assign mem_op_in = (c_in.mem_read | c_in.mem_write) & ~bubble;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)    q <= '0;
        else if (adv) q <= bubble ? '0 : ex_in;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (adv)                        state_n = mem_op_in ? WAIT : IDLE;
        else if (state == WAIT && dhit) state_n = DONE;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ld_hold <= '0;
            halt_q  <= 1'b0;
        end else begin
            if (state == WAIT && dhit && q.ctrl.mem_read) ld_hold <= dmemload;
            halt_q <= halt_out;
        end
    end

    assign mem_stall = (state == WAIT) & ~dhit;
    assign dmemREN   = (state == WAIT) & q.ctrl.mem_read;
    assign dmemWEN   = (state == WAIT) & q.ctrl.mem_write;
    assign dmemaddr  = q.alu;
    assign dmemstore = q.rdat2;

    // the dhit cycle forwards the load straight through so it needs no extra cycle
    assign load_data    = (state == WAIT && dhit) ? dmemload : ld_hold;
    assign wdat_out     = q.ctrl.jal ? q.npc : q.ctrl.mem_to_reg ? load_data : q.alu;
    assign for_dat_mem  = wdat_out;
    assign regSel_out   = q.ctrl.jal ? {REG_W{1'b1}} : q.reg_sel;
    assign regWrite_out = q.ctrl.reg_write & ~mem_stall;

    assign pc_redirect = (q.ctrl.branch_sel | q.ctrl.jump) & ~mem_stall;
    assign pc_target   = q.ctrl.jump ? q.jaddr : q.baddr;

    assign halt_out = halt_q | (q.ctrl.halt & ~mem_stall);

endmodule
